// File: rtl/known_ch_pkg.sv
// Shared types and constants for the known-cluster-head table.
// A table entry is one packed record; the helper saturates the hop increment.
package known_ch_pkg;

    localparam int DEF_WORD_WIDTH = 16;
    localparam int DEF_DEPTH      = 8;

    localparam logic [DEF_WORD_WIDTH-1:0] NO_CH    = 16'd0;
    localparam logic [DEF_WORD_WIDTH-1:0] HOPS_INF = 16'hFFFF;

    typedef struct packed {
        logic                      valid;
        logic [DEF_WORD_WIDTH-1:0] id;
        logic [DEF_WORD_WIDTH-1:0] hops;
        logic [DEF_WORD_WIDTH-1:0] qvalue;
    } ch_entry_t;

    function automatic logic [DEF_WORD_WIDTH-1:0] satInc(input logic [DEF_WORD_WIDTH-1:0] v);
        return (v == HOPS_INF) ? HOPS_INF : v + 16'd1;
    endfunction

endpackage

// File: rtl/known_ch_select.sv
// Combinational argmax over the CH table: highest Q, then fewest hops,
// then lowest index. found_o is low when no entry is valid.
module known_ch_select
    import known_ch_pkg::*;
#(
    parameter  int DEPTH = DEF_DEPTH,
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  ch_entry_t          entries_i [DEPTH],
    output logic [IDX_W-1:0]   bestIdx_o,
    output logic               found_o
);

    logic [DEF_WORD_WIDTH-1:0] bestQ;
    logic [DEF_WORD_WIDTH-1:0] bestHops;

    // Strict comparisons keep the earlier (lower-index) entry on a full tie.
    always_comb begin
        bestIdx_o = '0;
        found_o   = 1'b0;
        bestQ     = '0;
        bestHops  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entries_i[i].valid &&
                (!found_o ||
                 entries_i[i].qvalue > bestQ ||
                 (entries_i[i].qvalue == bestQ && entries_i[i].hops < bestHops))) begin
                found_o   = 1'b1;
                bestIdx_o = IDX_W'(i);
                bestQ     = entries_i[i].qvalue;
                bestHops  = entries_i[i].hops;
            end
        end
    end

endmodule

// File: rtl/known_ch_v2.sv
// Known-CH table: records CH advertisements between heartbeats and publishes
// the best CH with this node's hop distance to it, one edge after the table.
module known_ch_v2
    import known_ch_pkg::*;
#(
    parameter  int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter  int DEPTH      = DEF_DEPTH,
    localparam int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  en_KCH,
    input  logic                  HB_reset,
    input  logic [WORD_WIDTH-1:0] HB_CHlimit,
    input  logic [WORD_WIDTH-1:0] fCH_ID,
    input  logic [WORD_WIDTH-1:0] fCH_Hops,
    input  logic [WORD_WIDTH-1:0] fCH_QValue,
    output logic [WORD_WIDTH-1:0] chosenCH,
    output logic [WORD_WIDTH-1:0] hopsfromCH
);

    ch_entry_t             entries_q [DEPTH];
    ch_entry_t             entries_d [DEPTH];
    logic [WORD_WIDTH-1:0] count_q, count_d;
    logic [WORD_WIDTH-1:0] limit_q, limit_d;
    logic [WORD_WIDTH-1:0] chosen_q, chosen_d;
    logic [WORD_WIDTH-1:0] hops_q, hops_d;

    logic [WORD_WIDTH-1:0] effLimit;
    logic                  matchHit, freeHit, minHit;
    logic [IDX_W-1:0]      matchIdx, freeIdx, minIdx;
    logic [WORD_WIDTH-1:0] minQ;
    logic [IDX_W-1:0]      bestIdx;
    logic                  bestFound;

    assign effLimit = (limit_q > WORD_WIDTH'(DEPTH)) ? WORD_WIDTH'(DEPTH) : limit_q;

    known_ch_select #(.DEPTH(DEPTH)) uSelect (
        .entries_i (entries_q),
        .bestIdx_o (bestIdx),
        .found_o   (bestFound)
    );

    // Locate an existing ID, the first free slot and the weakest valid entry.
    always_comb begin
        matchHit = 1'b0;
        matchIdx = '0;
        freeHit  = 1'b0;
        freeIdx  = '0;
        minHit   = 1'b0;
        minIdx   = '0;
        minQ     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entries_q[i].valid && entries_q[i].id == fCH_ID && !matchHit) begin
                matchHit = 1'b1;
                matchIdx = IDX_W'(i);
            end
            if (!entries_q[i].valid && !freeHit) begin
                freeHit = 1'b1;
                freeIdx = IDX_W'(i);
            end
            if (entries_q[i].valid && (!minHit || entries_q[i].qvalue < minQ)) begin
                minHit = 1'b1;
                minIdx = IDX_W'(i);
                minQ   = entries_q[i].qvalue;
            end
        end
    end

    // Heartbeat wins over a same-cycle advertisement.
    always_comb begin
        entries_d = entries_q;
        count_d   = count_q;
        limit_d   = limit_q;
        if (HB_reset) begin
            for (int i = 0; i < DEPTH; i++) entries_d[i].valid = 1'b0;
            count_d = '0;
            limit_d = HB_CHlimit;
        end else if (en_KCH && fCH_ID != NO_CH) begin
            if (matchHit) begin
                entries_d[matchIdx].hops   = fCH_Hops;
                entries_d[matchIdx].qvalue = fCH_QValue;
            end else if (count_q < effLimit) begin
                entries_d[freeIdx] = '{valid: 1'b1, id: fCH_ID, hops: fCH_Hops, qvalue: fCH_QValue};
                count_d = count_q + 1'b1;
            end else if (minHit && fCH_QValue > minQ) begin
                entries_d[minIdx] = '{valid: 1'b1, id: fCH_ID, hops: fCH_Hops, qvalue: fCH_QValue};
            end
        end
    end

    always_comb begin
        chosen_d = NO_CH;
        hops_d   = HOPS_INF;
        if (bestFound) begin
            chosen_d = entries_q[bestIdx].id;
            hops_d   = satInc(entries_q[bestIdx].hops);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
            count_q  <= '0;
            limit_q  <= '0;
            chosen_q <= NO_CH;
            hops_q   <= HOPS_INF;
        end else begin
            entries_q <= entries_d;
            count_q   <= count_d;
            limit_q   <= limit_d;
            chosen_q  <= chosen_d;
            hops_q    <= hops_d;
        end
    end

    assign chosenCH   = chosen_q;
    assign hopsfromCH = hops_q;

endmodule

// File: tb/tb_known_ch_v2.sv
// Bench for known_ch_v2: directed scenarios followed by random traffic, all
// checked every cycle against a slot-level model of the CH table.
module tb_known_ch_v2;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        nrst;
    logic        enKch;
    logic        hbReset;
    logic [15:0] hbLimit;
    logic [15:0] fId;
    logic [15:0] fHops;
    logic [15:0] fQ;
    logic [15:0] chosenCH;
    logic [15:0] hopsfromCH;

    int total = 0;
    int bad   = 0;

    bit          mValid [DEPTH];
    logic [15:0] mId    [DEPTH];
    logic [15:0] mHops  [DEPTH];
    logic [15:0] mQ     [DEPTH];
    int          mCount;
    int          mLimit;
    logic [15:0] expChosen;
    logic [15:0] expHops;

    known_ch_v2 dut (
        .clk        (clk),
        .nrst       (nrst),
        .en_KCH     (enKch),
        .HB_reset   (hbReset),
        .HB_CHlimit (hbLimit),
        .fCH_ID     (fId),
        .fCH_Hops   (fHops),
        .fCH_QValue (fQ),
        .chosenCH   (chosenCH),
        .hopsfromCH (hopsfromCH)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit hb, input logic [15:0] lim, input bit en,
                                 input logic [15:0] id, input logic [15:0] hops, input logic [15:0] q);
        hbReset = hb;
        hbLimit = lim;
        enKch   = en;
        fId     = id;
        fHops   = hops;
        fQ      = q;
    endtask

    function automatic void modelClear(input bit full);
        for (int i = 0; i < DEPTH; i++) mValid[i] = 1'b0;
        mCount = 0;
        if (full) mLimit = 0;
    endfunction

    // Best = maximum Q, then minimum hops among those, then the first slot.
    function automatic void modelSelect();
        int  bestQ    = -1;
        int  bestHops = 1 << 20;
        expChosen = 16'd0;
        expHops   = 16'hFFFF;
        for (int i = 0; i < DEPTH; i++)
            if (mValid[i] && int'(mQ[i]) > bestQ) bestQ = int'(mQ[i]);
        for (int i = 0; i < DEPTH; i++)
            if (mValid[i] && int'(mQ[i]) == bestQ && int'(mHops[i]) < bestHops) bestHops = int'(mHops[i]);
        for (int i = DEPTH - 1; i >= 0; i--)
            if (mValid[i] && int'(mQ[i]) == bestQ && int'(mHops[i]) == bestHops) begin
                expChosen = mId[i];
                expHops   = (bestHops >= 16'hFFFF) ? 16'hFFFF : 16'(bestHops + 1);
            end
    endfunction

    function automatic void modelUpdate();
        int lim;
        int slot;
        if (hbReset) begin
            modelClear(1'b0);
            mLimit = int'(hbLimit);
            return;
        end
        if (!enKch || fId == 16'd0) return;
        for (int i = 0; i < DEPTH; i++)
            if (mValid[i] && mId[i] == fId) begin
                mHops[i] = fHops;
                mQ[i]    = fQ;
                return;
            end
        lim = (mLimit < DEPTH) ? mLimit : DEPTH;
        slot = -1;
        if (mCount < lim) begin
            for (int i = DEPTH - 1; i >= 0; i--) if (!mValid[i]) slot = i;
            mCount++;
        end else begin
            int lowQ = 1 << 20;
            for (int i = 0; i < DEPTH; i++)
                if (mValid[i] && int'(mQ[i]) < lowQ) begin
                    lowQ = int'(mQ[i]);
                    slot = i;
                end
            if (slot >= 0 && int'(fQ) <= lowQ) slot = -1;
        end
        if (slot >= 0) begin
            mValid[slot] = 1'b1;
            mId[slot]    = fId;
            mHops[slot]  = fHops;
            mQ[slot]     = fQ;
        end
    endfunction

    // One edge: outputs show the selection of the table as it was before the edge.
    task automatic tick();
        @(posedge clk);
        if (!nrst) begin
            modelClear(1'b1);
            expChosen = 16'd0;
            expHops   = 16'hFFFF;
        end else begin
            modelSelect();
            modelUpdate();
        end
        #1;
        checkOutput("chosen", chosenCH, expChosen);
        checkOutput("hops", hopsfromCH, expHops);
    endtask

    task automatic advertise(input logic [15:0] id, input logic [15:0] hops, input logic [15:0] q);
        applyStimulus(1'b0, 16'd0, 1'b1, id, hops, q);
        tick();
        applyStimulus(1'b0, 16'd0, 1'b0, 16'd0, 16'd0, 16'd0);
        tick();
    endtask

    task automatic heartbeat(input logic [15:0] lim);
        applyStimulus(1'b1, lim, 1'b0, 16'd0, 16'd0, 16'd0);
        tick();
        applyStimulus(1'b0, 16'd0, 1'b0, 16'd0, 16'd0, 16'd0);
    endtask

    task automatic midReset();
        nrst = 1'b0;
        #1;
        checkOutput("async_rst_chosen", chosenCH, 16'd0);
        checkOutput("async_rst_hops", hopsfromCH, 16'hFFFF);
        tick();
        nrst = 1'b1;
    endtask

    initial begin
        int r;
        logic [15:0] h;
        nrst = 1'b0;
        applyStimulus(1'b0, 16'd0, 1'b0, 16'd0, 16'd0, 16'd0);
        modelClear(1'b1);
        tick();
        tick();
        nrst = 1'b1;
        tick();
        checkOutput("idle_chosen", chosenCH, 16'd0);
        checkOutput("idle_hops", hopsfromCH, 16'hFFFF);

        heartbeat(16'd10);
        advertise(16'd5, 16'd2, 16'd100);
        checkOutput("single_chosen", chosenCH, 16'd5);
        checkOutput("single_hops", hopsfromCH, 16'd3);
        advertise(16'd7, 16'd4, 16'd200);
        checkOutput("better_q", chosenCH, 16'd7);
        checkOutput("better_q_hops", hopsfromCH, 16'd5);
        advertise(16'd9, 16'd1, 16'd200);
        checkOutput("tie_hops", chosenCH, 16'd9);
        checkOutput("tie_hops_hops", hopsfromCH, 16'd2);
        advertise(16'd9, 16'd1, 16'd50);
        checkOutput("update_in_place", chosenCH, 16'd7);

        heartbeat(16'd2);
        advertise(16'd1, 16'd0, 16'd10);
        advertise(16'd2, 16'd0, 16'd20);
        checkOutput("limit_two", chosenCH, 16'd2);
        advertise(16'd3, 16'd0, 16'd5);
        checkOutput("drop_weak", chosenCH, 16'd2);
        advertise(16'd4, 16'd0, 16'd30);
        checkOutput("replace_min", chosenCH, 16'd4);
        advertise(16'd4, 16'd0, 16'd1);
        checkOutput("replaced_gone", chosenCH, 16'd2);

        applyStimulus(1'b1, 16'd10, 1'b1, 16'd6, 16'd1, 16'd999);
        tick();
        applyStimulus(1'b0, 16'd0, 1'b0, 16'd0, 16'd0, 16'd0);
        tick();
        checkOutput("hb_strobe_chosen", chosenCH, 16'd0);
        checkOutput("hb_strobe_hops", hopsfromCH, 16'hFFFF);

        advertise(16'd3, 16'hFFFF, 16'd1);
        checkOutput("sat_hops", hopsfromCH, 16'hFFFF);
        advertise(16'd3, 16'hFFFE, 16'd1);
        checkOutput("near_sat_hops", hopsfromCH, 16'hFFFF);
        advertise(16'd0, 16'd0, 16'd500);
        checkOutput("id_zero_ignored", chosenCH, 16'd3);

        heartbeat(16'd0);
        advertise(16'd8, 16'd1, 16'd40);
        checkOutput("limit_zero", chosenCH, 16'd0);

        heartbeat(16'd10);
        advertise(16'd11, 16'd3, 16'd70);
        midReset();
        tick();
        checkOutput("post_rst_chosen", chosenCH, 16'd0);

        heartbeat(16'd12);
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 99);
            case ($urandom_range(0, 3))
                0:       h = 16'hFFFF;
                1:       h = 16'hFFFE;
                default: h = 16'($urandom_range(0, 5));
            endcase
            if (r < 4) begin
                applyStimulus(1'b1, 16'($urandom_range(0, 11)), $urandom_range(0, 1) == 1,
                              16'($urandom_range(1, 12)), h, 16'($urandom_range(0, 15)));
                tick();
            end else if (r < 75) begin
                applyStimulus(1'b0, 16'($urandom_range(0, 11)), 1'b1,
                              16'($urandom_range(0, 12)), h, 16'($urandom_range(0, 15)));
                tick();
            end else if (r == 99) begin
                midReset();
            end else begin
                applyStimulus(1'b0, 16'd0, 1'b0, 16'd0, 16'd0, 16'd0);
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
